// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants: bus widths and BRESP/RRESP response codes.
package axil_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_err_slave_wr.sv
// AXI4-Lite write error slave: terminates the interconnect's invalid-slave
// port, sinks every AW/W pair and answers each with RESP_CODE on B.
// Counts completed error responses in a saturating counter.
// Optional build macro AXIL_ERR_CAPTURE_EN adds err_addr/err_valid, which
// record the last faulting write address and whether any error completed.
module axil_err_slave_wr
  import axil_pkg::*;
#(
  parameter logic [1:0] RESP_CODE = RESP_DECERR,
  parameter int         CNT_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                        s_axil_awvalid,
  output logic                        s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                        s_axil_wvalid,
  output logic                        s_axil_wready,
  output logic [1:0]                  s_axil_bresp,
  output logic                        s_axil_bvalid,
  input  logic                        s_axil_bready,
  output logic [CNT_WIDTH-1:0]        err_count
`ifdef AXIL_ERR_CAPTURE_EN
  ,
  output logic [AXI_ADDR_WIDTH-1:0]   err_addr,
  output logic                        err_valid
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_W  = 2'd1,
    WAIT_AW = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic aw_fire;
  logic w_fire;
  logic b_fire;

  // Write data and strobes are discarded; address is only kept when capture is built in.
  logic unused_inputs;
  assign unused_inputs = ^{s_axil_wdata, s_axil_wstrb, s_axil_awaddr};

  assign aw_fire = s_axil_awvalid & s_axil_awready;
  assign w_fire  = s_axil_wvalid  & s_axil_wready;
  assign b_fire  = s_axil_bvalid  & s_axil_bready;

  // State register; reset drops any half-collected or pending write silently.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: collect one AW and one W in either order, then respond.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (aw_fire && w_fire) state_nxt = RESP;
        else if (aw_fire)      state_nxt = WAIT_W;
        else if (w_fire)       state_nxt = WAIT_AW;
      end
      WAIT_W:  if (w_fire)  state_nxt = RESP;
      WAIT_AW: if (aw_fire) state_nxt = RESP;
      RESP:    if (b_fire)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state only, so ready never depends on valid.
  always_comb begin
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_bvalid  = 1'b0;
    s_axil_bresp   = RESP_OKAY;
    case (state)
      IDLE: begin
        s_axil_awready = 1'b1;
        s_axil_wready  = 1'b1;
      end
      WAIT_W:  s_axil_wready  = 1'b1;
      WAIT_AW: s_axil_awready = 1'b1;
      RESP: begin
        s_axil_bvalid = 1'b1;
        s_axil_bresp  = RESP_CODE;
      end
      default: ;
    endcase
  end

  // Error counter: one per B handshake, holds at all-ones instead of wrapping.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                       err_count <= '0;
    else if (b_fire && (~err_count != '0)) err_count <= err_count + 1'b1;
  end

`ifdef AXIL_ERR_CAPTURE_EN
  // Capture: latest accepted write address, and a sticky flag after the first error response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_addr  <= '0;
      err_valid <= 1'b0;
    end else begin
      if (aw_fire) err_addr  <= s_axil_awaddr;
      if (b_fire)  err_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axil_err_slave_wr.sv
// Bench for axil_err_slave_wr: directed scenarios plus random traffic, both
// checked every cycle against a transaction-level model (one address and one
// data beat collected in any order, then one error response). A second
// instance with a 2-bit counter shares the stimulus to exercise saturation.
// Build with AXIL_ERR_CAPTURE_EN defined to also check err_addr/err_valid.
module tb_axil_err_slave_wr;
  import axil_pkg::*;

  logic                        aclk = 1'b0;
  logic                        aresetn;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic                        awvalid;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        bready;

  logic        awready_a, wready_a, bvalid_a;
  logic [1:0]  bresp_a;
  logic [15:0] cnt_a;
  logic        awready_b, wready_b, bvalid_b;
  logic [1:0]  bresp_b;
  logic [1:0]  cnt_b;
`ifdef AXIL_ERR_CAPTURE_EN
  logic [AXI_ADDR_WIDTH-1:0] eaddr_a, eaddr_b;
  logic                      evld_a, evld_b;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Model: transaction view of the slave
  bit          m_have_aw, m_have_w, m_resp, m_ever_b;
  int          m_count;
  logic [31:0] m_addr;

  always #5 aclk = ~aclk;

  axil_err_slave_wr dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready_a),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready_a),
    .s_axil_bresp(bresp_a), .s_axil_bvalid(bvalid_a), .s_axil_bready(bready),
    .err_count(cnt_a)
`ifdef AXIL_ERR_CAPTURE_EN
    , .err_addr(eaddr_a), .err_valid(evld_a)
`endif
  );

  axil_err_slave_wr #(.RESP_CODE(2'b11), .CNT_WIDTH(2)) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready_b),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready_b),
    .s_axil_bresp(bresp_b), .s_axil_bvalid(bvalid_b), .s_axil_bready(bready),
    .err_count(cnt_b)
`ifdef AXIL_ERR_CAPTURE_EN
    , .err_addr(eaddr_b), .err_valid(evld_b)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have_aw = 0; m_have_w = 0; m_resp = 0; m_ever_b = 0;
    m_count = 0; m_addr = '0;
  endtask

  // Compare every observable output with what the model predicts now.
  task automatic check_outputs(input string tag);
    int sat_a, sat_b;
    sat_a = (m_count > 65535) ? 65535 : m_count;
    sat_b = (m_count > 3) ? 3 : m_count;
    check({tag, ".awready"}, 64'(awready_a), 64'(!m_resp && !m_have_aw));
    check({tag, ".wready"},  64'(wready_a),  64'(!m_resp && !m_have_w));
    check({tag, ".bvalid"},  64'(bvalid_a),  64'(m_resp));
    check({tag, ".bresp"},   64'(bresp_a),   m_resp ? 64'd3 : 64'd0);
    check({tag, ".count"},   64'(cnt_a),     64'(sat_a));
    check({tag, ".bvalid2"}, 64'(bvalid_b),  64'(m_resp));
    check({tag, ".count2"},  64'(cnt_b),     64'(sat_b));
`ifdef AXIL_ERR_CAPTURE_EN
    check({tag, ".err_addr"},  64'(eaddr_a), 64'(m_addr));
    check({tag, ".err_valid"}, 64'(evld_a),  64'(m_ever_b));
    check({tag, ".err_addr2"}, 64'(eaddr_b), 64'(m_addr));
`endif
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model
  // to what the slave should hold after the coming edge.
  task automatic step(input string tag, input bit av, input logic [31:0] ad,
                      input bit wv, input bit br);
    bit aw_ok, w_ok;
    @(posedge aclk); #1;
    awvalid = av; awaddr = ad; wvalid = wv; bready = br;
    wdata = $urandom; wstrb = 4'($urandom);
    @(negedge aclk);
    check_outputs(tag);
    aw_ok = av && !m_resp && !m_have_aw;
    w_ok  = wv && !m_resp && !m_have_w;
    if (aw_ok) m_addr = ad;
    if (m_resp && br) begin
      m_resp = 0; m_count++; m_ever_b = 1;
    end else begin
      if (aw_ok) m_have_aw = 1;
      if (w_ok)  m_have_w  = 1;
      if (m_have_aw && m_have_w) begin
        m_resp = 1; m_have_aw = 0; m_have_w = 0;
      end
    end
  endtask

  initial begin
    aresetn = 1'b0; awvalid = 0; wvalid = 0; bready = 0;
    awaddr = '0; wdata = '0; wstrb = '0;
    model_reset();
    #12;
    check_outputs("reset");
    #10 aresetn = 1'b1;

    // Joint AW+W, bready high
    step("joint0", 1, 32'hDEAD_0000, 1, 1);
    step("joint1", 0, 32'h0, 0, 1);
    step("joint2", 0, 32'h0, 0, 1);

    // AW first, W three cycles later
    step("awf0", 1, 32'h0000_1000, 0, 1);
    step("awf1", 0, 32'h0, 0, 1);
    step("awf2", 0, 32'h0, 0, 1);
    step("awf3", 0, 32'h0, 1, 1);
    step("awf4", 0, 32'h0, 0, 1);
    step("awf5", 0, 32'h0, 0, 1);

    // W first, mirrored
    step("wf0", 0, 32'h0, 1, 1);
    step("wf1", 0, 32'h0, 0, 1);
    step("wf2", 0, 32'h0, 0, 1);
    step("wf3", 1, 32'h0000_2000, 0, 1);
    step("wf4", 0, 32'h0, 0, 1);
    step("wf5", 0, 32'h0, 0, 1);

    // Backpressure with new requests offered while responding
    step("bp0", 1, 32'h0000_3000, 1, 0);
    for (int i = 0; i < 5; i++) step("bp", 1, 32'h0000_4000 + i, 1, 0);
    step("bp_rel", 0, 32'h0, 0, 1);
    step("bp_idle", 0, 32'h0, 0, 1);

    // Capture: 0x100 then 0x200
    step("cap0", 1, 32'h0000_0100, 1, 1);
    step("cap1", 0, 32'h0, 0, 1);
    step("cap2", 1, 32'h0000_0200, 1, 1);
    step("cap3", 0, 32'h0, 0, 1);
    step("cap4", 0, 32'h0, 0, 1);

    // Reset while waiting for W
    step("rst0", 1, 32'h0000_5000, 0, 1);
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    #1 aresetn = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(posedge aclk); #2 aresetn = 1'b1;
    // A lone W must now park, not complete the discarded write
    step("rst_w", 0, 32'h0, 1, 1);
    step("rst_w1", 0, 32'h0, 0, 1);
    step("rst_w2", 0, 32'h0, 0, 1);
    step("rst_aw", 1, 32'h0000_6000, 0, 1);
    step("rst_aw1", 0, 32'h0, 0, 1);
    step("rst_aw2", 0, 32'h0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step("rand", bit'($urandom_range(0, 1)), $urandom,
           bit'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
